ddr_ctl_front: RTL and testbench

- Parametrised successor to the fixed 4-byte DDR controller instruction front-end.
- Accepts the same 12-bit {opcode, immediate} instruction stream and assembles address and data words of configurable byte width using auto-incrementing byte pointers.
- Issues page write/read commands to a DDR back-end over a valid/ready command channel and latches read responses into `page`.
- Adds behaviour the previous generation lacks: a sticky error flag, a response timeout, and protocol checking on lock state and busy state.

---
 rtl/ddr_ctl_front.sv | 229 ++++++++++++++++++++++
 tb/tb_ddr_ctl_front.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ctl_front.sv
// ---------------------------------------------------------------------------
// ddr_ctl_front
//
// Instruction front-end for a DDR page controller. A 12-bit {opcode,
// immediate} stream loads the command address and the write data one byte at
// a time through auto-incrementing byte pointers. The stream also issues page
// write/read commands to a back-end over a valid/ready channel. Read responses
// are latched into `page`. Protocol violations and read timeouts set a
// sticky error flag that only CLR (or reset) clears.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. While cmd_valid is 1 and cmd_ready is 0, cmd_write,
// cmd_addr and cmd_data hold steady. rsp_valid is a single-cycle strobe that
// is only looked at while a read is waiting for its data.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   inst       in   [11:8] opcode, [7:0] immediate byte
//   inst_en    in   inst valid this cycle
//   page       out  last page returned by a read
//   ready      out  idle, accepting instructions
//   locked     out  load window open (between LCK and ULK)
//   error      out  sticky protocol / timeout error
//   cmd_valid  out  command presented to back-end
//   cmd_ready  in   back-end accepts command
//   cmd_write  out  1 = write page, 0 = read page
//   cmd_addr   out  command address
//   cmd_data   out  write data
//   rsp_valid  in   read data valid
//   rsp_data   in   read data
// ---------------------------------------------------------------------------
module ddr_ctl_front #(
   parameter int ADDR_BYTES = 4,
   parameter int DATA_BYTES = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [11:0]             inst,
   input  logic                    inst_en,
   output logic [8*DATA_BYTES-1:0] page,
   output logic                    ready,
   output logic                    locked,
   output logic                    error,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic                    cmd_write,
   output logic [8*ADDR_BYTES-1:0] cmd_addr,
   output logic [8*DATA_BYTES-1:0] cmd_data,
   input  logic                    rsp_valid,
   input  logic [8*DATA_BYTES-1:0] rsp_data
);

   localparam int AW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam int DW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [AW-1:0] A_LAST = AW'(ADDR_BYTES - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DATA_BYTES - 1);
   localparam logic [15:0]   T_LAST = 16'(TIMEOUT - 1);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LCK = 4'd1;
   localparam logic [3:0] OP_ULK = 4'd2;
   localparam logic [3:0] OP_LA  = 4'd3;
   localparam logic [3:0] OP_LD  = 4'd4;
   localparam logic [3:0] OP_WRP = 4'd5;
   localparam logic [3:0] OP_RDP = 4'd6;
   localparam logic [3:0] OP_CLR = 4'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
   logic [8*DATA_BYTES-1:0] data_q, data_d;
   logic [AW-1:0]           aptr_q, aptr_d;
   logic [DW-1:0]           dptr_q, dptr_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [8*DATA_BYTES-1:0] page_q, page_d;
   logic                    locked_q, locked_d;
   logic                    error_q, error_d;
   logic                    cmd_write_q, cmd_write_d;
   logic [8*ADDR_BYTES-1:0] cmd_addr_q, cmd_addr_d;
   logic [8*DATA_BYTES-1:0] cmd_data_q, cmd_data_d;

   logic [3:0] op;
   logic [7:0] imm;
   logic       accept;

   assign op     = inst[11:8];
   assign imm    = inst[7:0];
   assign accept = inst_en && (state_q == S_IDLE);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      aptr_d      = aptr_q;
      dptr_d      = dptr_q;
      cnt_d       = cnt_q;
      page_d      = page_q;
      locked_d    = locked_q;
      error_d     = error_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;

      // Instructions arriving while busy are dropped; only NOP is harmless.
      if (inst_en && (state_q != S_IDLE) && (op != OP_NOP)) begin
         error_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_NOP: ;
                  OP_LCK: begin
                     locked_d = 1'b1;
                     aptr_d   = '0;
                     dptr_d   = '0;
                  end
                  OP_ULK: locked_d = 1'b0;
                  OP_LA: begin
                     if (locked_q) begin
                        addr_d[{aptr_q, 3'b000} +: 8] = imm;
                        aptr_d = (aptr_q == A_LAST) ? '0 : aptr_q + AW'(1);
                     end else begin
                        error_d = 1'b1;
                     end
                  end
                  OP_LD: begin
                     if (locked_q) begin
                        data_d[{dptr_q, 3'b000} +: 8] = imm;
                        dptr_d = (dptr_q == D_LAST) ? '0 : dptr_q + DW'(1);
                     end else begin
                        error_d = 1'b1;
                     end
                  end
                  OP_WRP, OP_RDP: begin
                     if (locked_q) begin
                        error_d = 1'b1;
                     end else begin
                        // Snapshot the registers so later loads cannot
                        // disturb a command in flight.
                        state_d     = S_ISSUE;
                        cmd_write_d = (op == OP_WRP);
                        cmd_addr_d  = addr_q;
                        cmd_data_d  = data_q;
                     end
                  end
                  OP_CLR: begin
                     error_d = 1'b0;
                     aptr_d  = '0;
                     dptr_d  = '0;
                  end
                  default: error_d = 1'b1;
               endcase
            end
         end

         S_ISSUE: begin
            if (cmd_ready) begin
               state_d = cmd_write_q ? S_IDLE : S_WAIT;
               cnt_d   = '0;
            end
         end

         S_WAIT: begin
            // A response in the expiry cycle still counts as on time.
            if (rsp_valid) begin
               page_d  = rsp_data;
               state_d = S_IDLE;
            end else if (cnt_q == T_LAST) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         aptr_q      <= '0;
         dptr_q      <= '0;
         cnt_q       <= '0;
         page_q      <= '0;
         locked_q    <= 1'b0;
         error_q     <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         aptr_q      <= aptr_d;
         dptr_q      <= dptr_d;
         cnt_q       <= cnt_d;
         page_q      <= page_d;
         locked_q    <= locked_d;
         error_q     <= error_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_data_q  <= cmd_data_d;
      end
   end

   assign page      = page_q;
   assign ready     = (state_q == S_IDLE);
   assign locked    = locked_q;
   assign error     = error_q;
   assign cmd_valid = (state_q == S_ISSUE);
   assign cmd_write = cmd_write_q;
   assign cmd_addr  = cmd_addr_q;
   assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_ddr_ctl_front.sv
// ---------------------------------------------------------------------------
// tb_ddr_ctl_front
//
// Directed scenarios followed by randomized instruction traffic. The
// reference model keeps the address/data registers as byte arrays with
// integer pointers and predicts every visible output.
// ---------------------------------------------------------------------------
module tb_ddr_ctl_front;

   localparam int AB = 4;
   localparam int DB = 4;
   localparam int TO = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] inst;
   logic        inst_en;
   logic [31:0] page;
   logic        ready, locked, error;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_data;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   ddr_ctl_front #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .TIMEOUT(TO)) dut (
      .clock     (clock),
      .reset     (reset),
      .inst      (inst),
      .inst_en   (inst_en),
      .page      (page),
      .ready     (ready),
      .locked    (locked),
      .error     (error),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit          m_locked, m_error, m_issue, m_write;
   int          m_aptr, m_dptr;
   logic [7:0]  m_addr [AB];
   logic [7:0]  m_data [DB];
   logic [31:0] m_page, m_caddr, m_cdata;

   function automatic logic [31:0] pack_addr();
      logic [31:0] v;
      for (int i = 0; i < AB; i++) v[8*i +: 8] = m_addr[i];
      return v;
   endfunction

   function automatic logic [31:0] pack_data();
      logic [31:0] v;
      for (int i = 0; i < DB; i++) v[8*i +: 8] = m_data[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk1({tag, ".ready"}, ready, 1'b1);
      chk1({tag, ".cmd_valid"}, cmd_valid, 1'b0);
      chk1({tag, ".locked"}, locked, m_locked);
      chk1({tag, ".error"}, error, m_error);
      chk32({tag, ".page"}, page, m_page);
   endtask

   task automatic chk_cmd(input string tag);
      chk1({tag, ".cmd_valid"}, cmd_valid, 1'b1);
      chk1({tag, ".ready"}, ready, 1'b0);
      chk1({tag, ".cmd_write"}, cmd_write, m_write);
      chk32({tag, ".cmd_addr"}, cmd_addr, m_caddr);
      chk32({tag, ".cmd_data"}, cmd_data, m_cdata);
      chk1({tag, ".error"}, error, m_error);
   endtask

   task automatic model_reset();
      m_locked = 0; m_error = 0; m_issue = 0; m_write = 0;
      m_aptr = 0; m_dptr = 0;
      m_page = '0; m_caddr = '0; m_cdata = '0;
      for (int i = 0; i < AB; i++) m_addr[i] = '0;
      for (int i = 0; i < DB; i++) m_data[i] = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      chk_idle("reset");
      chk1("reset.cmd_write", cmd_write, 1'b0);
      chk32("reset.cmd_addr", cmd_addr, 32'h0);
      chk32("reset.cmd_data", cmd_data, 32'h0);
   endtask

   // Effect of one instruction accepted while idle.
   task automatic model_inst(input logic [3:0] op, input logic [7:0] imm);
      m_issue = 0;
      case (op)
         4'd0: ;
         4'd1: begin m_locked = 1; m_aptr = 0; m_dptr = 0; end
         4'd2: m_locked = 0;
         4'd3: if (m_locked) begin m_addr[m_aptr] = imm; m_aptr = (m_aptr + 1) % AB; end
               else m_error = 1;
         4'd4: if (m_locked) begin m_data[m_dptr] = imm; m_dptr = (m_dptr + 1) % DB; end
               else m_error = 1;
         4'd5, 4'd6: if (m_locked) m_error = 1;
               else begin
                  m_issue = 1; m_write = (op == 4'd5);
                  m_caddr = pack_addr(); m_cdata = pack_data();
               end
         4'd7: begin m_error = 0; m_aptr = 0; m_dptr = 0; end
         default: m_error = 1;
      endcase
   endtask

   task automatic send(input logic [3:0] op, input logic [7:0] imm);
      inst = {op, imm};
      inst_en = 1'b1;
      tick();
      inst_en = 1'b0;
      model_inst(op, imm);
      if (m_issue) chk_cmd("issue");
      else chk_idle("inst");
   endtask

   // Completes a command that has just been issued.
   task automatic finish_cmd(input int stall, input int delay,
                             input logic [31:0] rdata, input bit inject);
      logic [3:0] jop;
      for (int i = 0; i < stall; i++) begin
         cmd_ready = 1'b0;
         if (inject) begin
            jop = 4'($urandom_range(0, 15));
            inst = {jop, 8'($urandom)};
            inst_en = 1'b1;
         end
         tick();
         inst_en = 1'b0;
         if (inject && jop != 4'd0) m_error = 1;
         chk_cmd("stall");
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      if (m_write) begin
         chk_idle("wr_done");
      end else if (delay < TO) begin
         for (int i = 0; i < delay; i++) begin
            tick();
            chk1("wait.ready", ready, 1'b0);
            chk1("wait.cmd_valid", cmd_valid, 1'b0);
         end
         rsp_valid = 1'b1;
         rsp_data = rdata;
         tick();
         rsp_valid = 1'b0;
         m_page = rdata;
         chk_idle("rd_done");
      end else begin
         for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk1("tmo_wait.ready", ready, 1'b0);
         end
         tick();
         m_error = 1;
         chk_idle("timeout");
         rsp_valid = 1'b1;
         rsp_data = ~rdata;
         tick();
         rsp_valid = 1'b0;
         chk_idle("late_rsp");
      end
   endtask

   initial begin
      logic [3:0] op;
      int sel;
      reset = 1'b1; inst = '0; inst_en = 1'b0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      model_reset();
      tick();
      do_reset();

      // Address/data load and write
      send(4'd1, 8'h00);
      send(4'd3, 8'h12); send(4'd3, 8'h3F); send(4'd3, 8'h2B); send(4'd3, 8'h00);
      send(4'd4, 8'hAA); send(4'd4, 8'hBB); send(4'd4, 8'hCC); send(4'd4, 8'hDD);
      send(4'd2, 8'h00);
      send(4'd5, 8'h00);
      chk32("plan.addr", cmd_addr, 32'h002B3F12);
      chk32("plan.data", cmd_data, 32'hDDCCBBAA);
      finish_cmd(0, 0, '0, 0);

      // Read with stall
      send(4'd6, 8'h00);
      finish_cmd(3, 5, 32'hEFEFEFEF, 0);
      chk32("plan.page", page, 32'hEFEFEFEF);

      // Pointer wrap
      send(4'd1, 8'h00);
      for (int i = 1; i <= 5; i++) send(4'd4, 8'(i));
      send(4'd2, 8'h00);
      send(4'd5, 8'h00);
      chk32("plan.wrap", cmd_data, 32'h04030205);
      finish_cmd(1, 0, '0, 0);

      // Protocol errors and disabled instruction
      send(4'd4, 8'h11);
      chk1("plan.ld_unlocked", error, 1'b1);
      send(4'd7, 8'h00);
      chk1("plan.clr", error, 1'b0);
      send(4'hF, 8'h00);
      chk1("plan.bad_op", error, 1'b1);
      send(4'd7, 8'h00);
      send(4'd1, 8'h00);
      inst = {4'd4, 8'h0A};
      inst_en = 1'b0;
      tick();
      chk_idle("inst_en_low");
      send(4'd5, 8'h00);
      chk1("plan.wrp_locked", cmd_valid, 1'b0);
      send(4'd2, 8'h00);
      send(4'd5, 8'h00);
      chk32("plan.no_ld", cmd_data, 32'h04030205);
      finish_cmd(0, 0, '0, 0);
      send(4'd7, 8'h00);

      // Timeout
      send(4'd6, 8'h00);
      finish_cmd(0, 100, 32'h12345678, 0);
      chk1("plan.timeout_err", error, 1'b1);
      send(4'd7, 8'h00);

      // Randomized traffic
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            inst = 12'($urandom);
            inst_en = 1'b0;
            tick();
            chk_idle("rand_idle");
         end
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: op = 4'($urandom_range(0, 15));
            3, 4:    op = 4'd3;
            5, 6:    op = 4'd4;
            7:       op = 4'd5;
            8:       op = 4'd6;
            default: op = $urandom_range(0, 1) ? 4'd1 : 4'd2;
         endcase
         send(op, 8'($urandom));
         if (m_issue)
            finish_cmd($urandom_range(0, 3), $urandom_range(0, 10),
                       $urandom, 1'($urandom_range(0, 1)));
      end

      // Reset during WAIT
      send(4'd2, 8'h00);
      send(4'd6, 8'h00);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      tick();
      chk1("wait_rst.pre_ready", ready, 1'b0);
      do_reset();
      rsp_valid = 1'b1;
      rsp_data = 32'hCAFEF00D;
      tick();
      rsp_valid = 1'b0;
      chk_idle("post_rst_rsp");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
